// File: rtl/cpu_csr_pkg.sv
// Shared machine-mode CSR definitions: CSR addresses, cause codes,
// mstatus/mie/mip bit positions and the trap controller state encoding.
package cpu_csr_pkg;

  // CSR address map
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Cause codes (low 4 bits of mcause)
  localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;
  localparam logic [3:0] CAUSE_M_EXT_IRQ      = 4'd11;

  // Bit positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  // Trap controller FSM; encoding kept fixed for legacy compatibility
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HANDLER = 2'd1,
    ST_TRAP    = 2'd2,
    ST_RET     = 2'd3
  } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// Machine-mode CSR storage for the trap controller: mtvec, mepc, mcause,
// mtval, mstatus.MIE/MPIE, mie.MEIE, plus the read-only mip.MEIP view.
// Ports:
//   i_clk, i_rst           clock, async active-high reset
//   i_csr_we/addr/wdata    software CSR write
//   o_csr_rdata            combinational CSR read
//   i_ext_irq              external interrupt level (mip.MEIP)
//   i_hw_entry             trap entry this edge (loads epc/cause/tval, stacks MIE)
//   i_hw_mret              mret this edge (unstacks MIE)
//   i_hw_epc/cause/tval    values captured on trap entry
//   o_mtvec, o_mepc        current mtvec / mepc
//   o_mie, o_meie          mstatus.MIE and mie.MEIE
module trap_csr_file
  import cpu_csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = 64'h0000_0000_8000_0100
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csr_we,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [XLEN-1:0] o_csr_rdata,
  input  logic            i_ext_irq,
  input  logic            i_hw_entry,
  input  logic            i_hw_mret,
  input  logic [XLEN-1:0] i_hw_epc,
  input  logic [XLEN-1:0] i_hw_cause,
  input  logic [XLEN-1:0] i_hw_tval,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc,
  output logic            o_mie,
  output logic            o_meie
);

  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic            r_mie;
  logic            r_mpie;
  logic            r_meie;

  logic            w_wr_mstatus;
  logic            w_wr_mie;
  logic            w_wr_mtvec;
  logic            w_wr_mepc;
  logic            w_wr_mcause;
  logic            w_wr_mtval;
  logic [1:0]      w_mtvec_mode;

  always_comb begin
    w_wr_mstatus = i_csr_we && (i_csr_addr == CSR_MSTATUS);
    w_wr_mie     = i_csr_we && (i_csr_addr == CSR_MIE);
    w_wr_mtvec   = i_csr_we && (i_csr_addr == CSR_MTVEC);
    w_wr_mepc    = i_csr_we && (i_csr_addr == CSR_MEPC);
    w_wr_mcause  = i_csr_we && (i_csr_addr == CSR_MCAUSE);
    w_wr_mtval   = i_csr_we && (i_csr_addr == CSR_MTVAL);
    // Reserved modes 2/3 leave the current mode untouched
    w_mtvec_mode = i_csr_wdata[1] ? r_mtvec[1:0] : i_csr_wdata[1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mtvec  <= MTVEC_RESET;
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_meie   <= 1'b0;
    end else begin
      if (w_wr_mtvec) r_mtvec <= {i_csr_wdata[XLEN-1:2], w_mtvec_mode};
      if (w_wr_mie)   r_meie  <= i_csr_wdata[MIE_MEIE_BIT];

      // Hardware trap/mret updates take precedence over software writes
      if (i_hw_entry) begin
        r_mepc   <= i_hw_epc;
        r_mcause <= i_hw_cause;
        r_mtval  <= i_hw_tval;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else begin
        if (w_wr_mepc)   r_mepc   <= {i_csr_wdata[XLEN-1:2], 2'b00};
        if (w_wr_mcause) r_mcause <= i_csr_wdata;
        if (w_wr_mtval)  r_mtval  <= i_csr_wdata;
        if (i_hw_mret) begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
          r_mie  <= i_csr_wdata[MSTATUS_MIE_BIT];
          r_mpie <= i_csr_wdata[MSTATUS_MPIE_BIT];
        end
      end
    end
  end

  always_comb begin
    o_csr_rdata = '0;
    case (i_csr_addr)
      CSR_MSTATUS: begin
        o_csr_rdata[MSTATUS_MIE_BIT]  = r_mie;
        o_csr_rdata[MSTATUS_MPIE_BIT] = r_mpie;
      end
      CSR_MIE:    o_csr_rdata[MIE_MEIE_BIT] = r_meie;
      CSR_MTVEC:  o_csr_rdata = r_mtvec;
      CSR_MEPC:   o_csr_rdata = r_mepc;
      CSR_MCAUSE: o_csr_rdata = r_mcause;
      CSR_MTVAL:  o_csr_rdata = r_mtval;
      CSR_MIP:    o_csr_rdata[MIP_MEIP_BIT] = i_ext_irq;
      default:    o_csr_rdata = '0;
    endcase
  end

  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;
  assign o_mie   = r_mie;
  assign o_meie  = r_meie;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller. Arbitrates fetch/decode exceptions, the
// external interrupt and mret, and drives the PC unit's redirect inputs.
// Ports:
//   clk, rst                          clock, async active-high reset
//   pc_en                             PC advance strobe (consumes a redirect)
//   pc_addr                           current PC
//   if_exc_en/code/val                fetch exception
//   id_exc_en/code/val                decode/execute exception
//   mret                              mret retiring
//   ext_irq                           external interrupt level
//   csr_we/addr/wdata, csr_rdata      CSR access path
//   pc_trap_taken, pc_trap            trap redirect request and target
//   trap_done, mepc_out               mret redirect request and target
//   in_trap                           trap handler active
module trap_ctrl
  import cpu_csr_pkg::*;
#(
  parameter logic [63:0] MTVEC_RESET = 64'h0000_0000_8000_0100,
  parameter int unsigned XLEN        = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            if_exc_en,
  input  logic [3:0]      if_exc_code,
  input  logic [XLEN-1:0] if_exc_val,
  input  logic            id_exc_en,
  input  logic [3:0]      id_exc_code,
  input  logic [XLEN-1:0] id_exc_val,
  input  logic            mret,
  input  logic            ext_irq,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            pc_trap_taken,
  output logic [XLEN-1:0] pc_trap,
  output logic            trap_done,
  output logic [XLEN-1:0] mepc_out,
  output logic            in_trap
);

  localparam logic [XLEN-1:0] PC_TRAP_RST = {MTVEC_RESET[XLEN-1:2], 2'b00};
  localparam logic [XLEN-1:0] IRQ_CAUSE   =
    {1'b1, {(XLEN-5){1'b0}}, CAUSE_M_EXT_IRQ};

  trap_state_e     r_state;
  trap_state_e     w_state_nxt;
  logic [XLEN-1:0] r_pc_trap;

  logic [XLEN-1:0] w_mtvec;
  logic [XLEN-1:0] w_mepc;
  logic            w_mie;
  logic            w_meie;

  logic            w_sample;
  logic            w_exc;
  logic            w_irq;
  logic            w_is_irq;
  logic            w_entry;
  logic            w_mret_go;
  logic [3:0]      w_code;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_tval;
  logic [XLEN-1:0] w_epc;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_target;

  always_comb begin
    w_sample  = (r_state == ST_IDLE) || (r_state == ST_HANDLER);
    w_exc     = if_exc_en || id_exc_en;
    w_irq     = ext_irq && w_mie && w_meie;
    w_is_irq  = !w_exc && w_irq;
    w_entry   = w_sample && (w_exc || w_irq);
    // An exception or interrupt in the same cycle suppresses mret
    w_mret_go = w_sample && mret && !w_exc && !w_irq;

    w_code    = if_exc_en ? if_exc_code : id_exc_code;
    w_cause   = w_is_irq ? IRQ_CAUSE : {{(XLEN-4){1'b0}}, w_code};
    w_tval    = w_is_irq ? '0 : (if_exc_en ? if_exc_val : id_exc_val);
    w_epc     = pc_addr & {{(XLEN-2){1'b1}}, 2'b00};

    w_base    = w_mtvec & {{(XLEN-2){1'b1}}, 2'b00};
    w_target  = w_base;
    if ((w_mtvec[1:0] == 2'b01) && w_is_irq)
      w_target = w_base + {{(XLEN-6){1'b0}}, CAUSE_M_EXT_IRQ, 2'b00};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_HANDLER: begin
        if (w_entry)        w_state_nxt = ST_TRAP;
        else if (w_mret_go) w_state_nxt = ST_RET;
      end
      ST_TRAP: if (pc_en) w_state_nxt = ST_HANDLER;
      ST_RET:  if (pc_en) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc_trap <= PC_TRAP_RST;
    end else begin
      r_state <= w_state_nxt;
      if (w_entry) r_pc_trap <= w_target;
    end
  end

  trap_csr_file #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_csr_we    (csr_we),
    .i_csr_addr  (csr_addr),
    .i_csr_wdata (csr_wdata),
    .o_csr_rdata (csr_rdata),
    .i_ext_irq   (ext_irq),
    .i_hw_entry  (w_entry),
    .i_hw_mret   (w_mret_go),
    .i_hw_epc    (w_epc),
    .i_hw_cause  (w_cause),
    .i_hw_tval   (w_tval),
    .o_mtvec     (w_mtvec),
    .o_mepc      (w_mepc),
    .o_mie       (w_mie),
    .o_meie      (w_meie)
  );

  assign pc_trap_taken = (r_state == ST_TRAP);
  assign trap_done     = (r_state == ST_RET);
  assign in_trap       = (r_state == ST_HANDLER);
  assign pc_trap       = r_pc_trap;
  assign mepc_out      = w_mepc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_en;
  logic [63:0] pc_addr;
  logic        if_exc_en;
  logic [3:0]  if_exc_code;
  logic [63:0] if_exc_val;
  logic        id_exc_en;
  logic [3:0]  id_exc_code;
  logic [63:0] id_exc_val;
  logic        mret;
  logic        ext_irq;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        pc_trap_taken;
  logic [63:0] pc_trap;
  logic        trap_done;
  logic [63:0] mepc_out;
  logic        in_trap;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  trap_ctrl #(
    .MTVEC_RESET (64'h0000_0000_8000_0100),
    .XLEN        (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_en         (pc_en),
    .pc_addr       (pc_addr),
    .if_exc_en     (if_exc_en),
    .if_exc_code   (if_exc_code),
    .if_exc_val    (if_exc_val),
    .id_exc_en     (id_exc_en),
    .id_exc_code   (id_exc_code),
    .id_exc_val    (id_exc_val),
    .mret          (mret),
    .ext_irq       (ext_irq),
    .csr_we        (csr_we),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata),
    .pc_trap_taken (pc_trap_taken),
    .pc_trap       (pc_trap),
    .trap_done     (trap_done),
    .mepc_out      (mepc_out),
    .in_trap       (in_trap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_en = 1'b0; pc_addr = '0;
    if_exc_en = 1'b0; if_exc_code = '0; if_exc_val = '0;
    id_exc_en = 1'b0; id_exc_code = '0; id_exc_val = '0;
    mret = 1'b0; ext_irq = 1'b0;
    csr_we = 1'b0; csr_addr = 12'h305; csr_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_total++;
    if (csr_rdata !== 64'h8000_0100)
      $display("FAIL reset_mtvec: got %h want %h", csr_rdata, 64'h8000_0100);
    else n_pass++;
    n_total++;
    if ({pc_trap_taken, trap_done, in_trap} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {pc_trap_taken, trap_done, in_trap});
    else n_pass++;
    n_total++;
    if (pc_trap !== 64'h8000_0100)
      $display("FAIL reset_pc_trap: got %h want %h", pc_trap, 64'h8000_0100);
    else n_pass++;
    n_total++;
    if (mepc_out !== 64'h0)
      $display("FAIL reset_mepc_out: got %h want 0", mepc_out);
    else n_pass++;
  endtask

  task automatic test_if_exception();
    pc_addr = 64'h8000_0002;
    if_exc_en = 1'b1; if_exc_code = 4'd0; if_exc_val = 64'h8000_0002;
    pc_en = 1'b0;
    tick();
    // fetch exception stays asserted; it must be ignored while in TRAP
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (pc_trap_taken !== 1'b1 || pc_trap !== 64'h8000_0100)
        $display("FAIL if_exc_hold[%0d]: got taken=%b pc_trap=%h want 1 %h",
                 i, pc_trap_taken, pc_trap, 64'h8000_0100);
      else n_pass++;
      if (i < 2) tick();
    end
    csr_addr = 12'h341; #1;
    n_total++;
    if (csr_rdata !== 64'h8000_0000)
      $display("FAIL if_exc_mepc: got %h want %h", csr_rdata, 64'h8000_0000);
    else n_pass++;
    csr_addr = 12'h343; #1;
    n_total++;
    if (csr_rdata !== 64'h8000_0002)
      $display("FAIL if_exc_mtval: got %h want %h", csr_rdata, 64'h8000_0002);
    else n_pass++;
    csr_addr = 12'h342; #1;
    n_total++;
    if (csr_rdata !== 64'h0)
      $display("FAIL if_exc_mcause: got %h want 0", csr_rdata);
    else n_pass++;
    pc_en = 1'b1; if_exc_en = 1'b0;
    tick();
    pc_en = 1'b0;
    n_total++;
    if (in_trap !== 1'b1 || pc_trap_taken !== 1'b0)
      $display("FAIL if_exc_handler: got in_trap=%b taken=%b want 1 0", in_trap, pc_trap_taken);
    else n_pass++;
  endtask

  task automatic test_irq();
    csr_write(12'h305, 64'h8000_0101);
    csr_write(12'h304, 64'h800);
    csr_write(12'h300, 64'h8);
    csr_addr = 12'h300; #1;
    n_total++;
    if (csr_rdata !== 64'h8)
      $display("FAIL irq_mstatus_set: got %h want %h", csr_rdata, 64'h8);
    else n_pass++;
    ext_irq = 1'b1;
    tick();
    ext_irq = 1'b0;
    n_total++;
    if (pc_trap_taken !== 1'b1 || pc_trap !== 64'h8000_012C)
      $display("FAIL irq_redirect: got taken=%b pc_trap=%h want 1 %h",
               pc_trap_taken, pc_trap, 64'h8000_012C);
    else n_pass++;
    csr_addr = 12'h342; #1;
    n_total++;
    if (csr_rdata !== 64'h8000_0000_0000_000B)
      $display("FAIL irq_mcause: got %h want %h", csr_rdata, 64'h8000_0000_0000_000B);
    else n_pass++;
    csr_addr = 12'h300; #1;
    n_total++;
    if (csr_rdata !== 64'h80)
      $display("FAIL irq_mstatus: got %h want %h", csr_rdata, 64'h80);
    else n_pass++;
    csr_addr = 12'h343; #1;
    n_total++;
    if (csr_rdata !== 64'h0)
      $display("FAIL irq_mtval: got %h want 0", csr_rdata);
    else n_pass++;
    pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    n_total++;
    if (in_trap !== 1'b1)
      $display("FAIL irq_handler: got in_trap=%b want 1", in_trap);
    else n_pass++;
  endtask

  task automatic test_mret();
    csr_write(12'h341, 64'h8000_0040);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    tick();
    n_total++;
    if (trap_done !== 1'b1 || in_trap !== 1'b0)
      $display("FAIL mret_done: got done=%b in_trap=%b want 1 0", trap_done, in_trap);
    else n_pass++;
    n_total++;
    if (mepc_out !== 64'h8000_0040)
      $display("FAIL mret_mepc_out: got %h want %h", mepc_out, 64'h8000_0040);
    else n_pass++;
    csr_addr = 12'h300; #1;
    n_total++;
    if (csr_rdata !== 64'h88)
      $display("FAIL mret_mstatus: got %h want %h", csr_rdata, 64'h88);
    else n_pass++;
    pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    n_total++;
    if ({pc_trap_taken, trap_done, in_trap} !== 3'b000)
      $display("FAIL mret_idle: got %b want 000", {pc_trap_taken, trap_done, in_trap});
    else n_pass++;
  endtask

  task automatic test_exc_mret_collision();
    pc_addr = 64'h8000_0203;
    id_exc_en = 1'b1; id_exc_code = 4'd11; id_exc_val = 64'h0;
    mret = 1'b1;
    csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 64'h1234;
    tick();
    id_exc_en = 1'b0; mret = 1'b0; csr_we = 1'b0;
    n_total++;
    if (pc_trap_taken !== 1'b1 || trap_done !== 1'b0)
      $display("FAIL coll_state: got taken=%b done=%b want 1 0", pc_trap_taken, trap_done);
    else n_pass++;
    n_total++;
    if (pc_trap !== 64'h8000_0100)
      $display("FAIL coll_pc_trap: got %h want %h", pc_trap, 64'h8000_0100);
    else n_pass++;
    csr_addr = 12'h341; #1;
    n_total++;
    if (csr_rdata !== 64'h8000_0200)
      $display("FAIL coll_mepc: got %h want %h", csr_rdata, 64'h8000_0200);
    else n_pass++;
    csr_addr = 12'h342; #1;
    n_total++;
    if (csr_rdata !== 64'd11)
      $display("FAIL coll_mcause: got %h want %h", csr_rdata, 64'd11);
    else n_pass++;
    csr_addr = 12'h300; #1;
    n_total++;
    if (csr_rdata !== 64'h80)
      $display("FAIL coll_mstatus: got %h want %h", csr_rdata, 64'h80);
    else n_pass++;
    pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    n_total++;
    if (in_trap !== 1'b1 || trap_done !== 1'b0)
      $display("FAIL coll_no_ret: got in_trap=%b done=%b want 1 0", in_trap, trap_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_trap();
    if_exc_en = 1'b1; if_exc_code = 4'd0; if_exc_val = 64'h55;
    pc_addr = 64'h8000_0300;
    tick();
    if_exc_en = 1'b0;
    n_total++;
    if (pc_trap_taken !== 1'b1)
      $display("FAIL nest_trap: got taken=%b want 1", pc_trap_taken);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if ({pc_trap_taken, trap_done, in_trap} !== 3'b000 || mepc_out !== 64'h0)
      $display("FAIL rst_mid_trap: got flags=%b mepc_out=%h want 000 0",
               {pc_trap_taken, trap_done, in_trap}, mepc_out);
    else n_pass++;
    n_total++;
    if (pc_trap !== 64'h8000_0100)
      $display("FAIL rst_mid_pc_trap: got %h want %h", pc_trap, 64'h8000_0100);
    else n_pass++;
    pc_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pc_en = 1'b0;
    n_total++;
    if ({pc_trap_taken, trap_done, in_trap} !== 3'b000)
      $display("FAIL rst_after: got %b want 000", {pc_trap_taken, trap_done, in_trap});
    else n_pass++;
  endtask

  task automatic test_csr_map();
    csr_write(12'h305, 64'h8000_0202);
    csr_addr = 12'h305; #1;
    n_total++;
    if (csr_rdata !== 64'h8000_0200)
      $display("FAIL mtvec_mode2: got %h want %h", csr_rdata, 64'h8000_0200);
    else n_pass++;
    csr_write(12'h341, 64'h1237);
    csr_addr = 12'h341; #1;
    n_total++;
    if (csr_rdata !== 64'h1234)
      $display("FAIL mepc_align: got %h want %h", csr_rdata, 64'h1234);
    else n_pass++;
    csr_write(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_addr = 12'h300; #1;
    n_total++;
    if (csr_rdata !== 64'h88)
      $display("FAIL mstatus_mask: got %h want %h", csr_rdata, 64'h88);
    else n_pass++;
    csr_write(12'h344, 64'hFFFF_FFFF_FFFF_FFFF);
    ext_irq = 1'b0;
    csr_addr = 12'h344; #1;
    n_total++;
    if (csr_rdata !== 64'h0)
      $display("FAIL mip_ro: got %h want 0", csr_rdata);
    else n_pass++;
    csr_addr = 12'h7C0; #1;
    n_total++;
    if (csr_rdata !== 64'h0)
      $display("FAIL unmapped_read: got %h want 0", csr_rdata);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_if_exception();
    test_irq();
    test_mret();
    test_exc_mret_collision();
    test_reset_mid_trap();
    test_csr_map();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap controller. It consumes the fetch/decode exception indications and the current PC, and drives the PC unit's trap-redirect inputs (pc_trap_taken, pc_trap, trap_done, mepc_out).
- Owns mtvec, mepc, mcause, mtval, mstatus (MIE/MPIE), mie (MEIE) and mip (MEIP).
- Sits between the PC unit, the decoder and the CSR access path of the execute stage.

Parameters:
- MTVEC_RESET, 64'h0000_0000_8000_0100, reset value of mtvec (direct mode).
- XLEN, 64, datapath width. Only 64 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_en  in  1  PC advance strobe; a redirect is consumed at a posedge with pc_en=1
- pc_addr  in  64  current PC
- if_exc_en  in  1  fetch exception (instruction address misaligned)
- if_exc_code  in  4  fetch exception cause code
- if_exc_val  in  64  fetch exception tval
- id_exc_en  in  1  decode/execute exception (illegal instruction, ecall, ebreak)
- id_exc_code  in  4  decode/execute exception cause code
- id_exc_val  in  64  decode/execute exception tval
- mret  in  1  mret instruction retiring
- ext_irq  in  1  external interrupt level
- csr_we  in  1  CSR write enable
- csr_addr  in  12  CSR address
- csr_wdata  in  64  CSR write data
- csr_rdata  out  64  CSR read data (combinational)
- pc_trap_taken  out  1  trap redirect request
- pc_trap  out  64  trap target address
- trap_done  out  1  mret redirect request
- mepc_out  out  64  return address
- in_trap  out  1  handler active (MIE cleared by trap entry, no mret yet)

Behaviour:
- Reset values:
  - State IDLE.
  - mtvec=MTVEC_RESET; mepc, mcause, mtval = 0.
  - MIE=0, MPIE=0, MEIE=0.
  - All outputs 0, except pc_trap = MTVEC_RESET with mode bits cleared.
- FSM states: IDLE, HANDLER, TRAP, RET. Outputs are Moore-decoded from registered state:
  - pc_trap_taken = (state==TRAP)
  - trap_done = (state==RET)
  - in_trap = (state==HANDLER)
- Events are sampled only in IDLE and HANDLER; at most one event per cycle, evaluated at posedge. Priority, highest first:
  1. if_exc_en
  2. id_exc_en
  3. interrupt, defined as ext_irq & MIE & MEIE
  4. mret
- Exception entry: next state TRAP. Capture in the same edge:
  - mepc={pc_addr[63:2],2'b00}
  - mcause={1'b0,59'b0,exc_code}
  - mtval=exc_val
  - MPIE=MIE, MIE=0
- Interrupt entry: same as exception entry, except mcause=64'h8000_0000_0000_000B and mtval=0.
- pc_trap:
  - mtvec mode 0: {mtvec[63:2],2'b00}
  - mode 1 and interrupt cause: base + 4*cause_code
  - mode 1 and exception: base
  - Registered with the entry.
- TRAP: hold all outputs; move to HANDLER at the first posedge with pc_en=1. Exception inputs are ignored while in TRAP, including a persistent misaligned-PC exc_en.
- mret in IDLE or HANDLER: next state RET. Same edge: MIE=MPIE, MPIE=1. mepc_out=mepc continuously.
- RET: move to IDLE at the first posedge with pc_en=1. Inputs are ignored while in RET.
- Exception and mret in the same cycle: the exception wins and mret is dropped (the faulting mret does not return).
- Exception in HANDLER (nested): allowed. Overwrites mepc, mcause and mtval; MPIE=MIE, which is 0.
- CSR writes at posedge when csr_we=1:
  - Address map: 0x300 mstatus (bits 3 MIE, 7 MPIE only), 0x304 mie (bit 11), 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x343 mtval. 0x344 mip is read-only: bit 11 = ext_irq.
  - mtvec write with mode 2 or 3 keeps the previous mode bits.
  - mepc write clears [1:0].
  - Writes to unmapped or read-only addresses are ignored.
- CSR reads: unmapped addresses read 0. Unimplemented mstatus bits read 0.
- Trap entry or mret in the same edge as a CSR write: hardware update wins for the registers it touches (mepc, mcause, mtval, mstatus). Other CSR writes still take effect.
- Reset mid-TRAP or mid-RET: immediate return to reset values; no redirect is issued.

Decomposition:
- Shared package cpu_csr_pkg holds:
  - CSR address constants
  - cause codes (INSTR_MISALIGN=0, ILLEGAL=2, BREAKPOINT=3, ECALL_M=11, M_EXT_IRQ=11)
  - mstatus bit indices
  - FSM state enum
- One sub-module: trap_csr_file, holding the CSR registers, read mux and write masking. The FSM stays in trap_ctrl.

Test Plan:
- Reset, then read 0x305 -> csr_rdata=0x8000_0100; pc_trap_taken=0, trap_done=0, state IDLE.
- if_exc_en=1, code 0, val 0x8000_0002, pc_addr=0x8000_0002, pc_en held 0 for 3 cycles:
  - pc_trap_taken=1 for those 3 cycles, pc_trap=0x8000_0100
  - mepc=0x8000_0000, mtval=0x8000_0002
  - then pc_en=1 -> HANDLER, in_trap=1.
- Set MIE=1 and MEIE=1, then assert ext_irq with mtvec=0x8000_0101 -> mcause=0x8000_0000_0000_000B, pc_trap=0x8000_012C, MIE=0, MPIE=1.
- In HANDLER, pulse mret with mepc=0x8000_0040 -> trap_done=1, mepc_out=0x8000_0040, MIE restored to 1; after pc_en, state IDLE.
- id_exc_en (ECALL, code 11) and mret in the same cycle, together with csr_we to mepc=0x1234 -> trap entry, mepc=pc_addr (write lost), no RET.
- Assert rst while in TRAP -> all outputs 0 immediately; pc_trap_taken never consumed.
